// File: rtl/cpu_apb_bridge_if.sv
// Bus bundles for the core-to-APB bridge.
//   cpu_bus_if : core data-bus port. The core is the master; the bridge is the slave.
//   apb_bus_if : APB peripheral bus. The bridge is the master; the peripheral is the slave.

interface cpu_bus_if;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata, cpu_err
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata, cpu_err
  );
endinterface

interface apb_bus_if;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready;
  logic        perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/cpu_apb_bridge.sv
// cpu_apb_bridge: single-outstanding bridge from the core data-bus port to APB.
// Every output is a flop. The *_d values are computed for the state being entered,
// so psel/penable/cpu_ready line up with the state they belong to.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no transfer; cpu_valid accepted here and request fields captured
// SETUP  | APB setup phase, psel=1 penable=0, always one cycle
// ACCESS | APB access phase, psel=1 penable=1, waits for pready or timeout
// RESP   | APB released, cpu_ready pulse, timeout counter cleared
//
// A timeout counter counts ACCESS cycles without pready. With TIMEOUT != 0 the
// transfer is aborted on the TIMEOUT-th such cycle, unless pready arrives in that
// same cycle, in which case the normal completion takes priority.

module cpu_apb_bridge #(
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned TO_W      = 9,
  parameter logic [31:0] ERR_RDATA = 32'h0
) (
  input  logic      APB_PCLK,
  input  logic      APB_PRESET,
  cpu_bus_if.slave  cpu,
  apb_bus_if.master apb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pdata_q, pdata_d;
  logic [3:0]      pstb_q, pstb_d;
  logic            pwrite_q, pwrite_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            cpu_ready_q, cpu_ready_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic            cpu_err_q, cpu_err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_hit;

  // Abort condition: the current ACCESS cycle is the last one allowed.
  assign timeout_hit = TO_EN && (to_cnt_q == TO_LAST);

  // Next-state and next-output logic; defaults first so nothing latches.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    pstb_d      = pstb_q;
    pwrite_d    = pwrite_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    to_cnt_d    = to_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu.cpu_valid) begin
          paddr_d  = cpu.cpu_addr;
          pdata_d  = cpu.cpu_wdata;
          pstb_d   = cpu.cpu_wstrb;
          pwrite_d = |cpu.cpu_wstrb;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (!apb.pready) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        if (apb.pready) begin
          // Writes return zero so stale peripheral data never reaches the core.
          cpu_rdata_d = pwrite_q ? 32'h0 : apb.prdata;
          cpu_err_d   = apb.perr;
          cpu_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          cpu_rdata_d = ERR_RDATA;
          cpu_err_d   = 1'b1;
          cpu_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end

      ST_RESP: begin
        // cpu_valid is deliberately not looked at here; the next request is
        // taken in IDLE, so back-to-back transfers are four cycles apart.
        to_cnt_d = '0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pdata_q     <= '0;
      pstb_q      <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      pstb_q      <= pstb_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign apb.paddr     = paddr_q;
  assign apb.pdata     = pdata_q;
  assign apb.pstb      = pstb_q;
  assign apb.pwrite    = pwrite_q;
  assign apb.psel      = psel_q;
  assign apb.penable   = penable_q;
  assign cpu.cpu_ready = cpu_ready_q;
  assign cpu.cpu_rdata = cpu_rdata_q;
  assign cpu.cpu_err   = cpu_err_q;

endmodule

// File: tb/tb_cpu_apb_bridge.sv
// Testbench for cpu_apb_bridge. Each request is expanded by a transaction model
// into its expected per-cycle bus picture (setup, n access cycles, response,
// one idle), and a compare process checks the DUT against that every cycle.
// A scripted APB slave answers after a programmed number of wait states.

module tb_cpu_apb_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk;
  logic rst;

  cpu_bus_if cpu_if ();
  apb_bus_if apb_if ();

  cpu_apb_bridge #(
    .TIMEOUT  (TO),
    .TO_W     (3),
    .ERR_RDATA(ERR)
  ) dut (
    .APB_PCLK  (clk),
    .APB_PRESET(rst),
    .cpu       (cpu_if),
    .apb       (apb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    logic        psel;
    logic        pen;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  stb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        model_q[$];
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_stb   = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;

  // waits < 0 means the slave never answers.
  task automatic push_tx(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input int waits, input logic [31:0] rd, input logic pe, output int n);
    bit   timed;
    exp_t e;
    if (waits >= 0 && waits + 1 <= TO) begin
      n = waits + 1;
      timed = 1'b0;
    end else begin
      n = TO;
      timed = 1'b1;
    end
    e.addr = a; e.wdata = wd; e.stb = st;
    e.rdata = timed ? ERR : ((st != 4'b0) ? 32'h0 : rd);
    e.err   = timed ? 1'b1 : pe;
    e.psel = 1'b1; e.pen = 1'b0; e.rdy = 1'b0;
    model_q.push_back(e);
    e.pen = 1'b1;
    for (int i = 0; i < n; i++) model_q.push_back(e);
    e.psel = 1'b0; e.pen = 1'b0; e.rdy = 1'b1;
    model_q.push_back(e);
    e.rdy = 1'b0;
    model_q.push_back(e);
  endtask

  // ---------------- scripted APB slave ----------------
  int          cur_waits  = 0;
  logic [31:0] cur_prdata = '0;
  logic        cur_perr   = 1'b0;

  initial begin
    int acc_cnt;
    acc_cnt = 0;
    apb_if.pready = 1'b0;
    apb_if.perr   = 1'b0;
    apb_if.prdata = '0;
    forever begin
      @(negedge clk);
      if (apb_if.psel && apb_if.penable) begin
        if (acc_cnt == cur_waits) begin
          apb_if.pready = 1'b1;
          apb_if.perr   = cur_perr;
          apb_if.prdata = cur_prdata;
        end else begin
          apb_if.pready = 1'b0;
          apb_if.perr   = 1'b1;
          apb_if.prdata = 32'hBAD0_BAD0;
        end
        acc_cnt++;
      end else begin
        // Noise outside ACCESS; the bridge must ignore it.
        acc_cnt = 0;
        apb_if.pready = 1'b1;
        apb_if.perr   = 1'b1;
        apb_if.prdata = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- monitor and per-cycle compare ----------------
  int          rdy_cyc[$];
  logic [31:0] rdy_data[$];
  logic        rdy_err[$];
  int          psel_cnt = 0;
  int          pen_cnt  = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_if.cpu_ready === 1'b1) begin
        rdy_cyc.push_back(cyc);
        rdy_data.push_back(cpu_if.cpu_rdata);
        rdy_err.push_back(cpu_if.cpu_err);
      end
      if (apb_if.psel === 1'b1) psel_cnt++;
      if (apb_if.penable === 1'b1) pen_cnt++;
      if (!rst) begin
        if (model_q.size() != 0) begin
          e = model_q.pop_front();
          m_addr = e.addr; m_wdata = e.wdata; m_stb = e.stb;
          if (e.rdy) begin
            m_rdata = e.rdata;
            m_err   = e.err;
          end
        end else begin
          e.psel = 1'b0; e.pen = 1'b0; e.rdy = 1'b0;
        end
        chk("psel", apb_if.psel, e.psel);
        chk("penable", apb_if.penable, e.pen);
        chk("cpu_ready", cpu_if.cpu_ready, e.rdy);
        chk("paddr", apb_if.paddr, m_addr);
        chk("pdata", apb_if.pdata, m_wdata);
        chk("pstb", apb_if.pstb, m_stb);
        chk("pwrite", apb_if.pwrite, |m_stb);
        chk("cpu_rdata", cpu_if.cpu_rdata, m_rdata);
        chk("cpu_err", cpu_if.cpu_err, m_err);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge inside the response cycle with
  // cpu_valid still high. b2b: the DUT is currently in RESP and will only take
  // this request one edge later.
  task automatic run_tx(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input int waits, input logic [31:0] rd, input logic pe,
                        input bit b2b, output int acc);
    int n;
    cur_waits = waits; cur_prdata = rd; cur_perr = pe;
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_addr  = a;
    cpu_if.cpu_wdata = wd;
    cpu_if.cpu_wstrb = st;
    push_tx(a, wd, st, waits, rd, pe, n);
    if (b2b) @(posedge clk);
    @(posedge clk);
    #1;
    acc = cyc;
    repeat (n + 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cpu_if.cpu_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    rdy_cyc.delete();
    rdy_data.delete();
    rdy_err.delete();
    psel_cnt = 0;
    pen_cnt  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc;
    rst = 1'b1;
    cpu_if.cpu_valid = 1'b0;
    cpu_if.cpu_addr  = '0;
    cpu_if.cpu_wdata = '0;
    cpu_if.cpu_wstrb = '0;
    repeat (2) @(negedge clk);

    chk("rst_psel", apb_if.psel, 1'b0);
    chk("rst_penable", apb_if.penable, 1'b0);
    chk("rst_pwrite", apb_if.pwrite, 1'b0);
    chk("rst_pstb", apb_if.pstb, 4'h0);
    chk("rst_paddr", apb_if.paddr, 32'h0);
    chk("rst_pdata", apb_if.pdata, 32'h0);
    chk("rst_cpu_ready", cpu_if.cpu_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_if.cpu_rdata, 32'h0);
    chk("rst_cpu_err", cpu_if.cpu_err, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: zero-wait read
    clr_mon();
    run_tx(32'h1000_0005, 32'h0, 4'b0000, 0, 32'h0000_0041, 1'b0, 1'b0, acc);
    idle(3);
    chk("t1_ready_count", rdy_cyc.size(), 1);
    chk("t1_ready_cycle", rdy_cyc[0] - acc + 1, 3);
    chk("t1_rdata", rdy_data[0], 32'h41);
    chk("t1_err", rdy_err[0], 1'b0);
    chk("t1_psel_cycles", psel_cnt, 2);
    chk("t1_penable_cycles", pen_cnt, 1);

    // 2: write, three wait states; pready lands on the timeout cycle and wins
    clr_mon();
    run_tx(32'h1000_0000, 32'h0000_00A5, 4'b0001, 3, 32'h1234_5678, 1'b0, 1'b0, acc);
    idle(3);
    chk("t2_ready_cycle", rdy_cyc[0] - acc + 1, 6);
    chk("t2_rdata", rdy_data[0], 32'h0);
    chk("t2_err", rdy_err[0], 1'b0);
    chk("t2_psel_cycles", psel_cnt, 5);
    chk("t2_penable_cycles", pen_cnt, 4);

    // 3: read with slave error
    clr_mon();
    run_tx(32'h1000_0008, 32'h0, 4'b0000, 1, 32'h0000_00C3, 1'b1, 1'b0, acc);
    idle(3);
    chk("t3_ready_cycle", rdy_cyc[0] - acc + 1, 4);
    chk("t3_rdata", rdy_data[0], 32'hC3);
    chk("t3_err", rdy_err[0], 1'b1);

    // 4: slave never answers -> timeout after exactly TO access cycles
    clr_mon();
    run_tx(32'h1000_0010, 32'h0, 4'b0000, -1, 32'h7777_7777, 1'b0, 1'b0, acc);
    idle(3);
    chk("t4_ready_count", rdy_cyc.size(), 1);
    chk("t4_ready_cycle", rdy_cyc[0] - acc + 1, 6);
    chk("t4_rdata", rdy_data[0], 32'hDEAD_BEEF);
    chk("t4_err", rdy_err[0], 1'b1);
    chk("t4_penable_cycles", pen_cnt, 4);

    // 5: reset during the second access cycle
    clr_mon();
    cur_waits = -1; cur_prdata = 32'h5555_5555; cur_perr = 1'b0;
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_addr  = 32'h1000_000C;
    cpu_if.cpu_wdata = 32'h0;
    cpu_if.cpu_wstrb = 4'b0000;
    push_tx(32'h1000_000C, 32'h0, 4'b0000, -1, 32'h5555_5555, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cpu_if.cpu_valid = 1'b0;
    model_q.delete();
    m_addr = '0; m_wdata = '0; m_stb = '0; m_rdata = '0; m_err = 1'b0;
    #1;
    chk("t5_psel_async", apb_if.psel, 1'b0);
    chk("t5_penable_async", apb_if.penable, 1'b0);
    chk("t5_rdata_cleared", cpu_if.cpu_rdata, 32'h0);
    chk("t5_access_before_rst", pen_cnt, 2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_ready", rdy_cyc.size(), 0);
    clr_mon();
    run_tx(32'h1000_0004, 32'h0, 4'b0000, 0, 32'h0000_0077, 1'b0, 1'b0, acc);
    idle(3);
    chk("t5_recover_cycle", rdy_cyc[0] - acc + 1, 3);
    chk("t5_recover_rdata", rdy_data[0], 32'h77);

    // 6: back-to-back reads with cpu_valid held high
    clr_mon();
    run_tx(32'h1000_0020, 32'h0, 4'b0000, 0, 32'h1111_0001, 1'b0, 1'b0, acc);
    run_tx(32'h1000_0024, 32'h0, 4'b0000, 0, 32'h2222_0002, 1'b0, 1'b1, acc);
    idle(3);
    chk("t6_ready_count", rdy_cyc.size(), 2);
    chk("t6_ready_spacing", rdy_cyc[1] - rdy_cyc[0], 4);
    chk("t6_rdata0", rdy_data[0], 32'h1111_0001);
    chk("t6_rdata1", rdy_data[1], 32'h2222_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
